// File: rtl/frame_buffer_ctrl.sv
// Frame memory endpoint for the 160x120 drawing path: pixel writes, a 2-cycle
// read-back port, and a full-screen clear sweep after reset or on request.
module frame_buffer_ctrl #(
  parameter int                 H_RES       = 160,
  parameter int                 V_RES       = 120,
  parameter int                 COLOR_W     = 3,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [7:0]         X_in,
  input  logic [6:0]         Y_in,
  input  logic [COLOR_W-1:0] Color_in,
  input  logic               plot_in,
  input  logic               clear_req,
  output logic               busy,
  input  logic               rd_req,
  input  logic [7:0]         rd_X,
  input  logic [6:0]         rd_Y,
  output logic               rd_valid,
  output logic [COLOR_W-1:0] rd_color,
  output logic               rd_oob
);

  localparam int                DEPTH      = H_RES * V_RES;
  localparam int                ADDR_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_RES);
  localparam logic [7:0]        X_LIM      = 8'(H_RES);
  localparam logic [6:0]        Y_LIM      = 7'(V_RES);

  // plot_in and rd_req are free-running strobes with no ready: every asserted
  // cycle is taken as one transaction, and rd_valid pulses once per accepted read.

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state, state_next;
  logic              clr_active;
  logic [ADDR_W-1:0] clr_ptr;

  logic [COLOR_W-1:0] mem [0:DEPTH-1];
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;
  logic [COLOR_W-1:0] mem_q;

  logic               wr_pend;
  logic [7:0]         wr_x;
  logic [6:0]         wr_y;
  logic [COLOR_W-1:0] wr_c;
  logic [ADDR_W-1:0]  wr_addr;

  logic               rd_v1, rd_oob1, rd_busy1;
  logic [7:0]         rd_x1;
  logic [6:0]         rd_y1;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_busy2, rd_have;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (clear_req) state_next = S_CLEAR;
      S_CLEAR: if (clr_ptr == LAST_ADDR) state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  always_comb begin
    busy       = (state == S_CLEAR);
    clr_active = (state == S_CLEAR);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)                                   clr_ptr <= '0;
    else if (clr_active && clr_ptr != LAST_ADDR) clr_ptr <= clr_ptr + 1'b1;
    else                                         clr_ptr <= '0;
  end

  // Coordinates are registered first; the address multiply sits behind them.
  always_ff @(posedge CLOCK_50) begin
    if (reset) wr_pend <= 1'b0;
    else       wr_pend <= plot_in && (state == S_IDLE) && (X_in < X_LIM) && (Y_in < Y_LIM);
    wr_x <= X_in;
    wr_y <= Y_in;
    wr_c <= Color_in;
  end

  assign wr_addr = ADDR_W'(wr_y) * ROW_STRIDE + ADDR_W'(wr_x);

  // The sweep owns the write port; a plot landing on the first sweep cycle
  // is dropped, which is invisible because the sweep clears every address.
  always_comb begin
    mem_we    = clr_active | wr_pend;
    mem_waddr = clr_active ? clr_ptr : wr_addr;
    mem_wdata = clr_active ? CLEAR_COLOR : wr_c;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) rd_v1 <= 1'b0;
    else       rd_v1 <= rd_req;
    rd_x1    <= rd_X;
    rd_y1    <= rd_Y;
    rd_oob1  <= (rd_X >= X_LIM) || (rd_Y >= Y_LIM);
    rd_busy1 <= busy;
  end

  assign rd_addr = ADDR_W'(rd_y1) * ROW_STRIDE + ADDR_W'(rd_x1);

  // Read-first: a read and a write of the same address in one cycle see old data.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_v1 && !rd_oob1) mem_q <= mem[rd_addr];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_oob   <= 1'b0;
      rd_busy2 <= 1'b0;
      rd_have  <= 1'b0;
    end else begin
      rd_valid <= rd_v1;
      if (rd_v1) begin
        rd_oob   <= rd_oob1;
        rd_busy2 <= rd_busy1;
        rd_have  <= 1'b1;
      end
    end
  end

  // Qualifiers only change on accepted reads, so the colour holds between pulses.
  assign rd_color = (!rd_have || rd_oob) ? '0 :
                    rd_busy2             ? CLEAR_COLOR : mem_q;

endmodule
